// File: rtl/dpram_port_arb_if.sv
// dpram_port_arb_if: one requester's handshake and data bus to the RAM port arbiter
interface dpram_port_arb_if #(parameter int ADDR_WIDTH = 3);
    logic                  req;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            we;
    logic [31:0]           dat_i;
    logic                  rdy;
    logic                  ack;
    logic [31:0]           dat_o;
    modport master (output req, lock, addr, we, dat_i, input rdy, ack, dat_o);
    modport slave  (input req, lock, addr, we, dat_i, output rdy, ack, dat_o);
endinterface

// File: rtl/dpram_port_arb.sv
// dpram_port_arb: round-robin arbiter with burst lock sharing one RAM port between two requesters
module dpram_port_arb #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_port_arb_if.slave       m0_if,
    dpram_port_arb_if.slave       m1_if,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [3:0]            ram_we_o,
    output logic [31:0]           ram_di_o,
    input  logic [31:0]           ram_do_i
);
    if (ADDR_WIDTH > 10) begin : g_width_check
        $error("ADDR_WIDTH must not exceed 10");
    end
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   rdy0_q, rdy1_q, ack0_q, ack1_q;
    logic   issue0, issue1;
    // next grant: a lock pins the current owner, otherwise the other requester gets the next turn
    always_comb begin
        issue0  = m0_if.req && rdy0_q;
        issue1  = m1_if.req && rdy1_q;
        state_d = state_q == GNT0 ? (m0_if.lock ? GNT0 : m1_if.req ? GNT1 : m0_if.req ? GNT0 : IDLE)
                : state_q == GNT1 ? (m1_if.lock ? GNT1 : m0_if.req ? GNT0 : m1_if.req ? GNT1 : IDLE)
                : (m0_if.req && m1_if.req) ? (last_q ? GNT0 : GNT1)
                : m0_if.req ? GNT0 : m1_if.req ? GNT1 : IDLE;
        last_d  = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : last_q;
    end
    // grant state, registered ready flags and one-cycle-delayed acks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rdy0_q  <= state_d == GNT0;
            rdy1_q  <= state_d == GNT1;
            ack0_q  <= issue0;
            ack1_q  <= issue1;
        end
    end
    assign m0_if.rdy   = rdy0_q;
    assign m1_if.rdy   = rdy1_q;
    assign m0_if.ack   = ack0_q;
    assign m1_if.ack   = ack1_q;
    assign m0_if.dat_o = ack0_q ? ram_do_i : 32'h0;
    assign m1_if.dat_o = ack1_q ? ram_do_i : 32'h0;
    assign ram_addr_o  = rdy1_q ? m1_if.addr : m0_if.addr;
    assign ram_di_o    = rdy1_q ? m1_if.dat_i : m0_if.dat_i;
    assign ram_we_o    = issue0 ? m0_if.we : issue1 ? m1_if.we : 4'h0;
endmodule

// File: tb/tb_dpram_port_arb.sv
// tb_dpram_port_arb: directed stimulus with an ack scoreboard against a byte-writable RAM model
module tb_dpram_port_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic [31:0] ram_do;
    logic [31:0] mem [8];
    logic [32:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    dpram_port_arb_if #(.ADDR_WIDTH(3)) m0();
    dpram_port_arb_if #(.ADDR_WIDTH(3)) m1();

    dpram_port_arb #(.ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_if      (m0),
        .m1_if      (m1),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .ram_di_o   (ram_di),
        .ram_do_i   (ram_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_do <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (m0.ack || m1.ack) begin
            logic [32:0] e;
            chk("ack_onehot", {31'h0, m0.ack & m1.ack}, 32'h0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got m0_ack=%0b m1_ack=%0b, want no ack", m0.ack, m1.ack);
            end else begin
                e = exp_q.pop_front();
                chk("ack_id", {31'h0, m1.ack}, {31'h0, e[32]});
                chk("ack_dat", m1.ack ? m1.dat_o : m0.dat_o, e[31:0]);
                chk("other_dat", m1.ack ? m0.dat_o : m1.dat_o, 32'h0);
            end
        end
    end

    task automatic access(input int m, input logic [2:0] a, input logic [3:0] w,
                          input logic [31:0] d, input logic [31:0] e);
        logic got;
        int   lat;
        exp_q.push_back({m[0], e});
        if (m == 0) begin
            m0.req = 1'b1; m0.addr = a; m0.we = w; m0.dat_i = d;
        end else begin
            m1.req = 1'b1; m1.addr = a; m1.we = w; m1.dat_i = d;
        end
        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = (m == 0) ? m0.rdy : m1.rdy;
            lat = n;
            if (!got) tick;
        end
        chk("access_rdy", {31'h0, got}, 32'h1);
        chk("access_latency", lat, 1);
        chk("access_we", {28'h0, ram_we}, {28'h0, w});
        chk("access_other_rdy", {31'h0, (m == 0) ? m1.rdy : m0.rdy}, 32'h0);
        tick;
        m0.req = 1'b0;
        m1.req = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + i;
        mem[5] = 32'hDEAD_BEEF;
        mem[2] = 32'h1122_3344;
        m0.req = 0; m0.lock = 0; m0.addr = 0; m0.we = 0; m0.dat_i = 0;
        m1.req = 0; m1.lock = 0; m1.addr = 0; m1.we = 0; m1.dat_i = 0;
        do_reset;
        @(negedge clk);
        chk("rst_rdy0", {31'h0, m0.rdy}, 32'h0);
        chk("rst_rdy1", {31'h0, m1.rdy}, 32'h0);
        chk("rst_ack", {30'h0, m0.ack, m1.ack}, 32'h0);
        chk("rst_we", {28'h0, ram_we}, 32'h0);
        tick;
        // single read, then byte write with read-before-write data, then read back
        access(0, 3'd5, 4'h0, 32'h0, 32'hDEAD_BEEF);
        repeat (2) tick;
        access(1, 3'd2, 4'b0100, 32'h00AA_0000, 32'h1122_3344);
        repeat (2) tick;
        access(0, 3'd2, 4'h0, 32'h0, 32'h11AA_3344);
        repeat (2) tick;
        // simultaneous requests after reset alternate m0, m1, ...
        do_reset;
        m0.req = 1; m0.addr = 3'd1; m0.we = 0;
        m1.req = 1; m1.addr = 3'd3; m1.we = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2) ? {1'b1, 32'hA000_0003} : {1'b0, 32'hA000_0001});
        @(negedge clk);
        chk("alt_c0_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick;
            @(negedge clk);
            chk("alt_rdy", {30'h0, m1.rdy, m0.rdy}, (i % 2) ? 32'h2 : 32'h1);
        end
        tick;
        m0.req = 0;
        m1.req = 0;
        repeat (3) tick;
        // locked burst by m1 with a two-cycle request gap while m0 waits
        m1.req = 1; m1.lock = 1; m1.addr = 3'd0; m1.we = 0;
        exp_q.push_back({1'b1, 32'hA000_0000});
        exp_q.push_back({1'b1, 32'hA000_0001});
        tick;
        m0.req = 1; m0.addr = 3'd7; m0.we = 0;
        @(negedge clk);
        chk("burst_c1_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        tick;
        m1.addr = 3'd1;
        @(negedge clk);
        chk("burst_c2_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        tick;
        m1.req = 0; m1.we = 4'hF; m1.dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("burst_gap1_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        chk("burst_gap1_we", {28'h0, ram_we}, 32'h0);
        tick;
        @(negedge clk);
        chk("burst_gap2_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        chk("burst_gap2_we", {28'h0, ram_we}, 32'h0);
        tick;
        m1.req = 1; m1.we = 0; m1.addr = 3'd2;
        exp_q.push_back({1'b1, 32'h11AA_3344});
        @(negedge clk);
        chk("burst_c5_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        tick;
        m1.addr = 3'd3; m1.lock = 0;
        exp_q.push_back({1'b1, 32'hA000_0003});
        exp_q.push_back({1'b0, 32'hA000_0007});
        @(negedge clk);
        chk("burst_c6_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h2);
        tick;
        m1.req = 0;
        @(negedge clk);
        chk("handover_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h1);
        tick;
        m0.req = 0;
        repeat (3) tick;
        // reset on the cycle after a locked write drops the ack and blocks writes
        m0.req = 1; m0.lock = 1; m0.addr = 3'd6; m0.we = 4'hF; m0.dat_i = 32'h5555_5555;
        tick;
        @(negedge clk);
        chk("rstmid_issue_rdy", {31'h0, m0.rdy}, 32'h1);
        chk("rstmid_issue_we", {28'h0, ram_we}, 32'hF);
        tick;
        rst = 1; m0.dat_i = 32'h1234_5678;
        @(negedge clk);
        chk("rstmid_ack", {30'h0, m0.ack, m1.ack}, 32'h0);
        chk("rstmid_dat", m0.dat_o, 32'h0);
        chk("rstmid_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h0);
        chk("rstmid_we", {28'h0, ram_we}, 32'h0);
        tick;
        @(negedge clk);
        chk("rstmid_we2", {28'h0, ram_we}, 32'h0);
        tick;
        rst = 0; m0.req = 0; m0.lock = 0; m0.we = 0;
        tick;
        access(1, 3'd6, 4'h0, 32'h0, 32'h5555_5555);
        repeat (2) tick;
        // single unlocked access then idle return
        access(0, 3'd4, 4'h0, 32'h0, 32'hA000_0004);
        tick;
        @(negedge clk);
        chk("idle_rdy", {30'h0, m1.rdy, m0.rdy}, 32'h0);
        chk("idle_we", {28'h0, ram_we}, 32'h0);
        repeat (3) tick;
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
